// File: rtl/operand_hazard_ctrl_if.sv
// rtl/operand_hazard_ctrl_if.sv - ID-stage hazard bus between the decode stage and the hazard controller
interface operand_hazard_ctrl_if #(
  parameter int STALL_CNT_W = 16
);
  logic [31:0]            i_instr_id;
  logic                   i_valid_id;
  logic                   i_flush;
  logic                   o_stall;
  logic [1:0]             o_fwd_a;
  logic [1:0]             o_fwd_b;
  logic [STALL_CNT_W-1:0] o_stall_cnt;

  modport master (
    output i_instr_id, i_valid_id, i_flush,
    input  o_stall, o_fwd_a, o_fwd_b, o_stall_cnt
  );

  modport slave (
    input  i_instr_id, i_valid_id, i_flush,
    output o_stall, o_fwd_a, o_fwd_b, o_stall_cnt
  );
endinterface

// File: rtl/operand_hazard_ctrl.sv
// rtl/operand_hazard_ctrl.sv - load-use/branch stall and registered EX forwarding selects
// Optional stall statistics counter enabled by HAZARD_STATS_EN.
module operand_hazard_ctrl #(
  parameter int STALL_CNT_W = 16
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  operand_hazard_ctrl_if.slave  bus
);
  localparam logic [5:0] OP_RTYPE = 6'h00, OP_BEQ  = 6'h04, OP_BNE  = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08, OP_ADDIU = 6'h09, OP_ANDI = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D, OP_XORI = 6'h0E, OP_LUI  = 6'h0F;
  localparam logic [5:0] OP_LW    = 6'h23, OP_SW   = 6'h2B;
  localparam logic [5:0] F_SLL  = 6'h00, F_SRL  = 6'h02, F_SRA  = 6'h03, F_SLLV = 6'h04;
  localparam logic [5:0] F_SRLV = 6'h06, F_SRAV = 6'h07, F_JR   = 6'h08, F_ADD  = 6'h20;
  localparam logic [5:0] F_ADDU = 6'h21, F_SUB  = 6'h22, F_SUBU = 6'h23, F_AND  = 6'h24;
  localparam logic [5:0] F_OR   = 6'h25, F_XOR  = 6'h26, F_NOR  = 6'h27, F_SLT  = 6'h2A;
  localparam logic [5:0] F_SLTU = 6'h2B;

  logic [5:0] opcode, func;
  logic [4:0] rs, rt, rd, dest;
  logic       rtype, r_alu, rs_read, rt_read, is_branch;
  logic       a_ex, b_ex, a_mem, b_mem, load_use, br_haz, stall, advance;
  logic       unused_shamt;

  logic       ex_valid_q, ex_valid_d, ex_load_q, ex_load_d;
  logic [4:0] ex_dest_q, ex_dest_d, mem_dest_q, mem_dest_d;
  logic       mem_valid_q, mem_valid_d;
  logic [1:0] fwd_a_q, fwd_a_d, fwd_b_q, fwd_b_d;

  assign opcode       = bus.i_instr_id[31:26];
  assign rs           = bus.i_instr_id[25:21];
  assign rt           = bus.i_instr_id[20:16];
  assign rd           = bus.i_instr_id[15:11];
  assign func         = bus.i_instr_id[5:0];
  assign unused_shamt = ^bus.i_instr_id[10:6];

  always_comb begin
    rtype     = (opcode == OP_RTYPE);
    r_alu     = rtype && (func inside {F_AND, F_OR, F_NOR, F_XOR, F_ADD, F_SUB, F_ADDU,
                                       F_SUBU, F_SLT, F_SLTU, F_SLLV, F_SRLV, F_SRAV});
    rs_read   = r_alu || (rtype && func == F_JR) ||
                (opcode inside {OP_ADDI, OP_ADDIU, OP_ANDI, OP_ORI, OP_XORI,
                                OP_LW, OP_SW, OP_BEQ, OP_BNE});
    rt_read   = r_alu || (rtype && (func inside {F_SLL, F_SRL, F_SRA})) ||
                (opcode inside {OP_SW, OP_BEQ, OP_BNE});
    is_branch = (opcode == OP_BEQ) || (opcode == OP_BNE) || (rtype && func == F_JR);
    dest      = 5'd0;
    if (opcode inside {OP_ANDI, OP_ORI, OP_XORI, OP_LUI, OP_ADDI, OP_ADDIU, OP_LW})
      dest = rt;
    else if (r_alu || (rtype && (func inside {F_SRL, F_SRA})))
      dest = rd;
  end

  // Register 0 reads never match: the producer side never records dest 0 as valid.
  always_comb begin
    a_ex     = rs_read && ex_valid_q  && (ex_dest_q  == rs);
    b_ex     = rt_read && ex_valid_q  && (ex_dest_q  == rt);
    a_mem    = rs_read && mem_valid_q && (mem_dest_q == rs);
    b_mem    = rt_read && mem_valid_q && (mem_dest_q == rt);
    load_use = ex_load_q && (a_ex || b_ex);
    br_haz   = is_branch && (a_ex || b_ex || a_mem || b_mem);
    stall    = bus.i_valid_id && !bus.i_flush && (load_use || br_haz);
    advance  = bus.i_valid_id && !bus.i_flush && !stall;
  end

  always_comb begin
    ex_valid_d  = advance && (dest != 5'd0);
    ex_dest_d   = dest;
    ex_load_d   = (opcode == OP_LW);
    mem_valid_d = ex_valid_q;
    mem_dest_d  = ex_dest_q;
    fwd_a_d     = 2'b00;
    fwd_b_d     = 2'b00;
    // Branches resolve in ID, so their operands never take EX bypass selects.
    if (advance && !is_branch) begin
      if (a_ex)       fwd_a_d = 2'b01;
      else if (a_mem) fwd_a_d = 2'b10;
      if (b_ex)       fwd_b_d = 2'b01;
      else if (b_mem) fwd_b_d = 2'b10;
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      ex_valid_q  <= 1'b0;
      ex_dest_q   <= 5'd0;
      ex_load_q   <= 1'b0;
      mem_valid_q <= 1'b0;
      mem_dest_q  <= 5'd0;
      fwd_a_q     <= 2'b00;
      fwd_b_q     <= 2'b00;
    end else begin
      ex_valid_q  <= ex_valid_d;
      ex_dest_q   <= ex_dest_d;
      ex_load_q   <= ex_load_d;
      mem_valid_q <= mem_valid_d;
      mem_dest_q  <= mem_dest_d;
      fwd_a_q     <= fwd_a_d;
      fwd_b_q     <= fwd_b_d;
    end
  end

  assign bus.o_stall = stall;
  assign bus.o_fwd_a = fwd_a_q;
  assign bus.o_fwd_b = fwd_b_q;

`ifdef HAZARD_STATS_EN
  logic [STALL_CNT_W-1:0] stall_cnt_q, stall_cnt_d;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (stall && (stall_cnt_q != {STALL_CNT_W{1'b1}}))
      stall_cnt_d = stall_cnt_q + STALL_CNT_W'(1);
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) stall_cnt_q <= '0;
    else          stall_cnt_q <= stall_cnt_d;
  end

  assign bus.o_stall_cnt = stall_cnt_q;
`else
  assign bus.o_stall_cnt = {STALL_CNT_W{1'b0}};
`endif
endmodule

// File: tb/tb_operand_hazard_ctrl.sv
// tb/tb_operand_hazard_ctrl.sv - scoreboard bench for operand_hazard_ctrl (HAZARD_STATS_EN optional)
module tb_operand_hazard_ctrl;
`ifdef HAZARD_STATS_EN
  localparam int CW = 2;
`else
  localparam int CW = 16;
`endif

  localparam logic [31:0] ADD3  = 32'h00221820;  // add $3,$1,$2
  localparam logic [31:0] LW4   = 32'h8C640000;  // lw $4,0($3)
  localparam logic [31:0] ADD5  = 32'h00812820;  // add $5,$4,$1
  localparam logic [31:0] ADDI0 = 32'h20200005;  // addi $0,$1,5
  localparam logic [31:0] ADD5Z = 32'h00002820;  // add $5,$0,$0
  localparam logic [31:0] BEQ45 = 32'h10850003;  // beq $4,$5
  localparam logic [31:0] ADD6  = 32'h00233020;  // add $6,$1,$3
  localparam logic [31:0] BUBL  = 32'h00000000;

  typedef struct {
    logic          stall;
    logic [1:0]    fa;
    logic [1:0]    fb;
    logic [CW-1:0] cnt;
    int            idx;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;
  exp_t exp_q[$];
  int checks = 0;
  int failures = 0;
  int step_no = 0;
  logic [CW-1:0] cnt_model = '0;

  operand_hazard_ctrl_if #(.STALL_CNT_W(CW)) bus ();

  operand_hazard_ctrl #(.STALL_CNT_W(CW)) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      checks += 4;
      if (bus.o_stall !== e.stall) begin
        failures++;
        $display("FAIL step%0d stall got=%0b exp=%0b", e.idx, bus.o_stall, e.stall);
      end
      if (bus.o_fwd_a !== e.fa) begin
        failures++;
        $display("FAIL step%0d fwd_a got=%0b exp=%0b", e.idx, bus.o_fwd_a, e.fa);
      end
      if (bus.o_fwd_b !== e.fb) begin
        failures++;
        $display("FAIL step%0d fwd_b got=%0b exp=%0b", e.idx, bus.o_fwd_b, e.fb);
      end
      if (bus.o_stall_cnt !== e.cnt) begin
        failures++;
        $display("FAIL step%0d stall_cnt got=%0d exp=%0d", e.idx, bus.o_stall_cnt, e.cnt);
      end
    end
  end

  // Expected fwd values are those visible during this step (latched on the previous edge).
  task automatic step(input logic [31:0] ins, input logic v, input logic fl, input logic rn,
                      input logic es, input logic [1:0] efa, input logic [1:0] efb);
    exp_t e;
    bus.i_instr_id = ins;
    bus.i_valid_id = v;
    bus.i_flush    = fl;
    rst_n          = rn;
    e.stall = es;
    e.fa    = efa;
    e.fb    = efb;
    e.cnt   = cnt_model;
    e.idx   = step_no;
    exp_q.push_back(e);
`ifdef HAZARD_STATS_EN
    if (!rn)                            cnt_model = '0;
    else if (es && (cnt_model != '1))   cnt_model = cnt_model + 1'b1;
`endif
    @(posedge clk);
    #1;
    step_no++;
  endtask

  initial begin
    rst_n          = 1'b0;
    bus.i_instr_id = BUBL;
    bus.i_valid_id = 1'b0;
    bus.i_flush    = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    // reset state
    step(BUBL,  0, 0, 0, 0, 2'b00, 2'b00);
    // add $3 then lw using $3: EX forward on A
    step(ADD3,  1, 0, 1, 0, 2'b00, 2'b00);
    step(LW4,   1, 0, 1, 0, 2'b00, 2'b00);
    // load-use: one stall, then MEM forward
    step(ADD5,  1, 0, 1, 1, 2'b01, 2'b00);
    step(ADD5,  1, 0, 1, 0, 2'b00, 2'b00);
    step(BUBL,  0, 0, 1, 0, 2'b10, 2'b00);
    // writes/reads of $0 never hazard
    step(ADDI0, 1, 0, 1, 0, 2'b00, 2'b00);
    step(ADD5Z, 1, 0, 1, 0, 2'b00, 2'b00);
    step(BUBL,  0, 0, 1, 0, 2'b00, 2'b00);
    step(BUBL,  0, 0, 1, 0, 2'b00, 2'b00);
    // lw then beq: two stall cycles
    step(LW4,   1, 0, 1, 0, 2'b00, 2'b00);
    step(BEQ45, 1, 0, 1, 1, 2'b00, 2'b00);
    step(BEQ45, 1, 0, 1, 1, 2'b00, 2'b00);
    step(BEQ45, 1, 0, 1, 0, 2'b00, 2'b00);
    step(BUBL,  0, 0, 1, 0, 2'b00, 2'b00);
    // flush overrides load-use stall
    step(LW4,   1, 0, 1, 0, 2'b00, 2'b00);
    step(ADD5,  1, 1, 1, 0, 2'b00, 2'b00);
    step(BUBL,  0, 0, 1, 0, 2'b00, 2'b00);
    // youngest producer wins; MEM forward on B
    step(ADD3,  1, 0, 1, 0, 2'b00, 2'b00);
    step(ADD3,  1, 0, 1, 0, 2'b00, 2'b00);
    step(LW4,   1, 0, 1, 0, 2'b00, 2'b00);
    step(ADD6,  1, 0, 1, 0, 2'b01, 2'b00);
    step(BUBL,  0, 0, 1, 0, 2'b00, 2'b10);
    // reset during a stall clears it
    step(LW4,   1, 0, 1, 0, 2'b00, 2'b00);
    step(ADD5,  1, 0, 0, 1, 2'b00, 2'b00);
    step(ADD5,  1, 0, 1, 0, 2'b00, 2'b00);
    step(BUBL,  0, 0, 1, 0, 2'b00, 2'b00);
    // lw then two branches then lw/add: five stall cycles, saturates a narrow counter
    step(LW4,   1, 0, 1, 0, 2'b00, 2'b00);
    step(BEQ45, 1, 0, 1, 1, 2'b00, 2'b00);
    step(BEQ45, 1, 0, 1, 1, 2'b00, 2'b00);
    step(LW4,   1, 0, 1, 0, 2'b00, 2'b00);
    step(BEQ45, 1, 0, 1, 1, 2'b00, 2'b00);
    step(BEQ45, 1, 0, 1, 1, 2'b00, 2'b00);
    step(LW4,   1, 0, 1, 0, 2'b00, 2'b00);
    step(ADD5,  1, 0, 1, 1, 2'b00, 2'b00);
    step(BUBL,  0, 0, 1, 0, 2'b00, 2'b00);
    step(BUBL,  0, 0, 1, 0, 2'b00, 2'b00);
    repeat (3) @(posedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL drain pending=%0d exp=0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/operand_hazard_ctrl.md
Name: operand_hazard_ctrl

Overview:
- Reader-side counterpart to the pipeline's destination decode.
- Decodes which source registers (rs/rt) the ID-stage instruction reads.
- Tracks the destination registers of in-flight instructions in the EX and MEM stages.
- Produces a load-use / branch stall and registered forwarding selects for the EX-stage ALU operand muxes. Sits between the ID stage and the ID/EX pipeline register.

Parameters:
- STALL_CNT_W, 16, width of the optional stall statistics counter.

Ports:
- i_clk  input  1  pipeline clock; all state updates on the rising edge.
- i_rst_n  input  1  synchronous reset, active-low.
- i_instr_id  input  32  instruction currently in the ID stage.
- i_valid_id  input  1  ID instruction is valid (not a bubble).
- i_flush  input  1  kill the ID instruction (taken branch/jump); a bubble enters EX.
- o_stall  output  1  hold PC and IF/ID, and insert a bubble into EX (combinational).
- o_fwd_a  output  2  EX operand A select: 00 regfile, 01 EX/MEM result, 10 MEM/WB result (registered).
- o_fwd_b  output  2  EX operand B select, same encoding (registered).
- o_stall_cnt  output  STALL_CNT_W  stall-cycle count (only with HAZARD_STATS_EN).

Behaviour:
- Source decode (combinational, ID instruction):
  - rs is read by opcode 0 with func in {AND,OR,NOR,XOR,ADD,SUB,ADDU,SUBU,SLT,SLTU,SLLV,SRLV,SRAV,JR}.
  - rs is also read by opcodes ADDI, ADDIU, ANDI, ORI, XORI, LW, SW, BEQ, BNE.
  - rt is read by opcode 0 with func in {AND,OR,NOR,XOR,ADD,SUB,ADDU,SUBU,SLT,SLTU,SLLV,SRLV,SRAV,SLL,SRL,SRA}, and by opcodes SW, BEQ, BNE.
  - LUI and J read no register.
  - A read of register 0 never creates a hazard.
- Destination decode (same table as the writer side):
  - Opcodes ANDI, ORI, XORI, LUI, ADDI, ADDIU, LW write rt.
  - Opcode 0 with func in {AND,OR,NOR,XOR,ADD,SUB,ADDU,SUBU,SLT,SLTU,SLLV,SRLV,SRAV,SRL,SRA} writes rd.
  - All other instructions have no destination.
  - A destination of 0 is treated as no write.
- Tracking state:
  - EX entry: {valid, dest[4:0], is_load}.
  - MEM entry: {valid, dest[4:0]}.
- Stall (combinational):
  - Load-use: o_stall=1 when i_valid_id, !i_flush, EX.valid, EX.is_load, and EX.dest equals a read source of the ID instruction.
  - Branch: o_stall=1 when the ID instruction is BEQ, BNE or JR and either EX.valid with EX.dest matching a source, or MEM.valid with MEM.dest matching a source.
  - Branches resolve in ID, so they receive no EX forwarding.
- Clock edge, !i_rst_n:
  - EX.valid=0, MEM.valid=0, o_fwd_a=00, o_fwd_b=00, o_stall_cnt=0.
  - o_stall is 0 after reset because both entries are invalid.
- Clock edge, normal operation:
  - MEM always takes the EX contents.
  - If o_stall or i_flush or !i_valid_id: EX.valid=0 and o_fwd_a/o_fwd_b=00.
  - Otherwise EX takes the ID destination decode and is_load (opcode LW).
- Forwarding selects, registered on the same edge the ID instruction enters EX:
  - 01 if the old EX entry (moving into MEM) writes the source.
  - Else 10 if the old MEM entry writes the source.
  - Else 00.
  - The youngest producer wins.
  - A source not read by the instruction gives 00.
- WB-stage producers are covered by the register file's internal write-then-read bypass. No select is generated for them.
- Simultaneous i_flush and o_stall condition: flush wins, a bubble enters EX, and o_stall is forced to 0.
- Reset asserted mid-stall: the stall clears on the next edge, and the pipeline state is fully invalid.

Optional Feature:
- Macro HAZARD_STATS_EN.
- When defined:
  - o_stall_cnt increments by 1 on each rising edge where o_stall=1.
  - It saturates at all-ones and does not wrap.
  - It clears on reset.
- When not defined:
  - The counter logic is absent.
  - o_stall_cnt is tied to 0.

Test Plan:
- ADD $3,$1,$2 (0x00221820) then LW $4,0($3) (0x8C640000): when LW enters EX, o_fwd_a=01, o_fwd_b=00, and there is no stall.
- LW $4,0($3) then ADD $5,$4,$1 (0x00812820): o_stall=1 for exactly 1 cycle. On the following edge the ADD enters EX with o_fwd_a=10 and o_fwd_b=00.
- ADDI $0,$1,5 (0x20200005) then ADD $5,$0,$0 (0x00002820): no stall, and o_fwd_a=o_fwd_b=00.
- LW $4,0($3) then BEQ $4,$5 (0x10850003): o_stall=1 for 2 cycles (EX match, then MEM match), then 0.
- LW $4 then ADD $5,$4,$1 with i_flush=1 on the ADD: o_stall=0, a bubble enters EX, and o_fwd=00. Reset asserted low during a stall drops o_stall the next cycle.
- With HAZARD_STATS_EN defined and STALL_CNT_W=2: 5 consecutive stall cycles give o_stall_cnt=3 (saturated).
